producer_ctrl: RTL and testbench

Parametrised production controller: it selects one of `N_SRC` data producers, gates that producer into the CDC buffer write port, and throttles on buffer-full. On stop or word-limit it drains the buffer and returns to idle. It generalises the two-source (fibonacci/timer) control FSM to N sources with configurable data width, a programmable word limit, and deterministic start/stop priority. It sits in the fast clock domain between the producers and the buffer wrapper, and drives the status LEDs and the display-module source code.

---
 rtl/producer_ctrl_pkg.sv | 21 ++
 rtl/edge_detector.sv | 26 ++
 rtl/producer_ctrl.sv | 156 +++++++++++++++
 tb/tb_producer_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/producer_ctrl_pkg.sv
// Shared types and encodings for the production controller.
package producer_ctrl_pkg;

   // Controller states: waiting, producing, throttled on full, draining.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COMM  = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   // One-hot LED patterns, one lamp per state.
   localparam logic [3:0] LED_IDLE  = 4'b0001;
   localparam logic [3:0] LED_COMM  = 4'b0010;
   localparam logic [3:0] LED_WAIT  = 4'b0100;
   localparam logic [3:0] LED_DRAIN = 4'b1000;

   // Display code shown while no producer is active.
   localparam int SRC_NONE = 0;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector for a raw level input; the history flop clears on
// reset so a level held through reset release yields one edge.
module edge_detector (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic din_q;
   logic din_d;

   // The history flop simply follows the input.
   always_comb begin
      din_d = din;
   end

   // History register, cleared by the active-low asynchronous reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) din_q <= 1'b0;
      else        din_q <= din_d;
   end

   assign rise = din & ~din_q;

endmodule

// File: rtl/producer_ctrl.sv
// Production controller: picks one of N_SRC producers, gates it into the
// buffer write port, throttles on full, and drains on stop or word limit.
module producer_ctrl
   import producer_ctrl_pkg::*;
#(
   parameter int N_SRC  = 2,
   parameter int DATA_W = 16,
   parameter int SEL_W  = $clog2(N_SRC + 1)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_SRC-1:0]          start,
   input  logic                      stop,
   input  logic [15:0]               word_limit,
   input  logic                      buffer_full,
   input  logic                      buffer_empty,
   input  logic                      data_2_valid,
   input  logic [N_SRC*DATA_W-1:0]   src_data,
   output logic [N_SRC-1:0]          src_en,
   output logic [DATA_W-1:0]         data_1,
   output logic                      data_1_en,
   output logic [SEL_W-1:0]          src_code,
   output logic [3:0]                led,
   output logic [15:0]               word_cnt,
   output logic                      limit_hit
);

   localparam int ACT_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   state_t             state_q, state_d;
   logic [ACT_W-1:0]   act_q, act_d;
   logic [15:0]        limit_q, limit_d;
   logic [15:0]        word_cnt_q, word_cnt_d;
   logic               limit_hit_q, limit_hit_d;

   logic [N_SRC-1:0]   start_rise;
   logic               stop_rise;
   logic               any_start;
   logic [ACT_W-1:0]   first_idx;
   logic               active;
   logic               last_write;

   // One edge detector per start line.
   for (genvar g = 0; g < N_SRC; g++) begin : g_start_edge
      edge_detector u_start_edge (
         .clock (clock),
         .reset (reset),
         .din   (start[g]),
         .rise  (start_rise[g])
      );
   end

   // Edge detector for the stop request.
   edge_detector u_stop_edge (
      .clock (clock),
      .reset (reset),
      .din   (stop),
      .rise  (stop_rise)
   );

   // Lowest-index start rise wins when several arrive together.
   always_comb begin
      first_idx = '0;
      any_start = |start_rise;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (start_rise[i]) first_idx = ACT_W'(i);
      end
   end

   // Write path: enable only the active producer while producing and not full,
   // so a full buffer never sees a write.
   always_comb begin
      src_en = '0;
      data_1 = '0;
      active = (state_q == S_COMM) || (state_q == S_WAIT);
      for (int i = 0; i < N_SRC; i++) begin
         if (act_q == ACT_W'(i)) begin
            src_en[i] = (state_q == S_COMM) && !buffer_full;
            if (active) data_1 = src_data[i*DATA_W +: DATA_W];
         end
      end
      data_1_en = |src_en;
   end

   // Next-state, run bookkeeping and status decode.
   always_comb begin
      state_d     = state_q;
      act_d       = act_q;
      limit_d     = limit_q;
      word_cnt_d  = word_cnt_q;
      limit_hit_d = limit_hit_q;
      last_write  = data_1_en && (limit_q != 16'd0) &&
                    ((word_cnt_q + 16'd1) == limit_q);

      if (data_1_en && (word_cnt_q != 16'hFFFF)) word_cnt_d = word_cnt_q + 16'd1;

      unique case (state_q)
         S_IDLE: begin
            if (any_start) begin
               act_d       = first_idx;
               limit_d     = word_limit;
               word_cnt_d  = 16'd0;
               limit_hit_d = 1'b0;
               state_d     = S_COMM;
            end
         end
         S_COMM: begin
            if (stop_rise)        state_d = S_DRAIN;
            else if (buffer_full) state_d = S_WAIT;
            else if (last_write) begin
               limit_hit_d = 1'b1;
               state_d     = S_DRAIN;
            end
         end
         S_WAIT: begin
            if (stop_rise)         state_d = S_DRAIN;
            else if (!buffer_full) state_d = S_COMM;
         end
         S_DRAIN: begin
            if (buffer_empty && !data_2_valid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      unique case (state_q)
         S_IDLE:  led = LED_IDLE;
         S_COMM:  led = LED_COMM;
         S_WAIT:  led = LED_WAIT;
         S_DRAIN: led = LED_DRAIN;
         default: led = LED_IDLE;
      endcase

      src_code = active ? (SEL_W'(act_q) + SEL_W'(1)) : SEL_W'(SRC_NONE);
   end

   // State and run registers, cleared by the active-low asynchronous reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         act_q       <= '0;
         limit_q     <= 16'd0;
         word_cnt_q  <= 16'd0;
         limit_hit_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         act_q       <= act_d;
         limit_q     <= limit_d;
         word_cnt_q  <= word_cnt_d;
         limit_hit_q <= limit_hit_d;
      end
   end

   assign word_cnt  = word_cnt_q;
   assign limit_hit = limit_hit_q;

endmodule

// File: tb/tb_producer_ctrl.sv
// Directed bench for producer_ctrl with two 16-bit producers.
module tb_producer_ctrl;

   logic        clock;
   logic        reset;
   logic [1:0]  start;
   logic        stop;
   logic [15:0] word_limit;
   logic        buffer_full;
   logic        buffer_empty;
   logic        data_2_valid;
   logic [31:0] src_data;
   logic [1:0]  src_en;
   logic [15:0] data_1;
   logic        data_1_en;
   logic [1:0]  src_code;
   logic [3:0]  led;
   logic [15:0] word_cnt;
   logic        limit_hit;

   int checkCount = 0;
   int errorCount = 0;
   int strobes;

   producer_ctrl #(.N_SRC(2), .DATA_W(16)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .word_limit   (word_limit),
      .buffer_full  (buffer_full),
      .buffer_empty (buffer_empty),
      .data_2_valid (data_2_valid),
      .src_data     (src_data),
      .src_en       (src_en),
      .data_1       (data_1),
      .data_1_en    (data_1_en),
      .src_code     (src_code),
      .led          (led),
      .word_cnt     (word_cnt),
      .limit_hit    (limit_hit)
   );

   // Free-running 10 ns clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one observed value against the bench's expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive the control inputs and let the combinational outputs settle.
   task automatic applyStimulus(input logic [1:0] st, input logic sp,
                                input logic full, input logic empty,
                                input logic valid);
      start        = st;
      stop         = sp;
      buffer_full  = full;
      buffer_empty = empty;
      data_2_valid = valid;
      #1;
   endtask

   // Advance one clock and step just past the edge.
   task automatic advanceClock();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset        = 1'b0;
      start        = 2'b00;
      stop         = 1'b0;
      word_limit   = 16'd0;
      buffer_full  = 1'b0;
      buffer_empty = 1'b1;
      data_2_valid = 1'b0;
      src_data     = {16'hB000, 16'hA000};

      // Reset values.
      repeat (2) advanceClock();
      checkOutput("rst_led",   led,       4'b0001);
      checkOutput("rst_en",    src_en,    2'b00);
      checkOutput("rst_data",  data_1,    16'h0000);
      checkOutput("rst_wr",    data_1_en, 1'b0);
      checkOutput("rst_code",  src_code,  2'd0);
      checkOutput("rst_cnt",   word_cnt,  16'd0);
      checkOutput("rst_hit",   limit_hit, 1'b0);
      reset = 1'b1;
      advanceClock();

      // Stop in IDLE is ignored.
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      advanceClock();
      checkOutput("idle_stop_led", led, 4'b0001);
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

      // Source 1, unlimited, never full.
      word_limit = 16'd0;
      applyStimulus(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
      advanceClock();
      for (int i = 0; i < 4; i++) begin
         src_data = {16'hB000 + 16'(i), 16'hA000 + 16'(i)};
         #1;
         checkOutput("s1_led",  led,       4'b0010);
         checkOutput("s1_en",   src_en,    2'b10);
         checkOutput("s1_code", src_code,  2'd2);
         checkOutput("s1_data", data_1,    16'hB000 + 16'(i));
         checkOutput("s1_wr",   data_1_en, 1'b1);
         checkOutput("s1_cnt",  word_cnt,  16'(i));
         advanceClock();
      end

      // Full for three cycles: write drops at once, WAIT, count frozen.
      applyStimulus(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("full0_led", led,       4'b0010);
      checkOutput("full0_wr",  data_1_en, 1'b0);
      checkOutput("full0_en",  src_en,    2'b00);
      checkOutput("full0_cnt", word_cnt,  16'd4);
      for (int i = 1; i <= 3; i++) begin
         advanceClock();
         if (i == 3) applyStimulus(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
         checkOutput("wait_led",  led,       4'b0100);
         checkOutput("wait_wr",   data_1_en, 1'b0);
         checkOutput("wait_cnt",  word_cnt,  16'd4);
         checkOutput("wait_code", src_code,  2'd2);
      end
      advanceClock();
      checkOutput("resume_led", led,       4'b0010);
      checkOutput("resume_wr",  data_1_en, 1'b1);
      checkOutput("resume_cnt", word_cnt,  16'd4);
      advanceClock();
      checkOutput("resume_cnt2", word_cnt, 16'd5);

      // Stop together with full: DRAIN; held valid keeps it there.
      applyStimulus(2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("stopfull_wr", data_1_en, 1'b0);
      advanceClock();
      applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("drain_led",  led,      4'b1000);
      checkOutput("drain_code", src_code, 2'd0);
      checkOutput("drain_data", data_1,   16'h0000);
      checkOutput("drain_wr",   data_1_en, 1'b0);
      checkOutput("drain_hit",  limit_hit, 1'b0);
      advanceClock();
      applyStimulus(2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("drain_hold1", led, 4'b1000);
      advanceClock();
      checkOutput("drain_hold2", led, 4'b1000);
      applyStimulus(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
      advanceClock();
      checkOutput("drain_exit", led,      4'b0001);
      checkOutput("drain_cnt",  word_cnt, 16'd5);

      // Word limit of 5 on source 0.
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      advanceClock();
      word_limit = 16'd5;
      applyStimulus(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
      advanceClock();
      strobes = 0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("lim_led",  led,      4'b0010);
         checkOutput("lim_code", src_code, 2'd1);
         checkOutput("lim_cnt",  word_cnt, 16'(i));
         if (data_1_en) strobes++;
         advanceClock();
      end
      if (data_1_en) strobes++;
      checkOutput("lim_strobes", strobes,   5);
      checkOutput("lim_led_dr",  led,       4'b1000);
      checkOutput("lim_hit",     limit_hit, 1'b1);
      checkOutput("lim_cnt_end", word_cnt,  16'd5);
      advanceClock();
      checkOutput("lim_idle",    led,       4'b0001);
      checkOutput("lim_sticky",  limit_hit, 1'b1);

      // Simultaneous starts pick source 0; later starts are ignored.
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      advanceClock();
      word_limit = 16'd0;
      src_data   = {16'hB123, 16'hA456};
      applyStimulus(2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
      advanceClock();
      checkOutput("both_code", src_code,  2'd1);
      checkOutput("both_en",   src_en,    2'b01);
      checkOutput("both_hit",  limit_hit, 1'b0);
      checkOutput("both_cnt",  word_cnt,  16'd0);
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      advanceClock();
      applyStimulus(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
      advanceClock();
      checkOutput("late_code", src_code, 2'd1);
      checkOutput("late_en",   src_en,   2'b01);
      checkOutput("late_data", data_1,   16'hA456);

      // Reset asserted in WAIT returns straight to IDLE.
      applyStimulus(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      advanceClock();
      checkOutput("pre_rst_led", led, 4'b0100);
      reset = 1'b0;
      #1;
      checkOutput("arst_led",  led,      4'b0001);
      checkOutput("arst_cnt",  word_cnt, 16'd0);
      checkOutput("arst_en",   src_en,   2'b00);
      checkOutput("arst_code", src_code, 2'd0);
      advanceClock();
      reset = 1'b1;
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      advanceClock();
      checkOutput("post_rst_led", led, 4'b0001);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
